baby_vga_fb_arbiter: RTL and testbench

Single-port access scheduler for the baby VGA line framebuffer (16 lines x 32 pixels, one 32-bit word per line). It shares the framebuffer's one read/write port between the video scanline fetcher and the TinyQV CPU bus. Video fetches have strict priority. CPU writes go through a small posted-write FIFO, and CPU reads are stalled via data_ready. It sits between the peripheral bus decode, the timing generator's line-fetch request and the framebuffer storage.

---
 rtl/baby_vga_pkg.sv | 20 ++
 rtl/baby_vga_fb_arbiter_if.sv | 23 ++
 rtl/baby_vga_wfifo.sv | 52 +++++
 rtl/baby_vga_fb_arbiter.sv | 172 +++++++++++++++++
 tb/tb_baby_vga_fb_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/baby_vga_pkg.sv
// Shared definitions for the baby VGA line framebuffer and its access arbiter.
package baby_vga_pkg;

    localparam int FB_LINES  = 16;
    localparam int FB_ADDR_W = 4;
    localparam int FB_DATA_W = 32;

    // TinyQV bus transfer codes on data_write_n / data_read_n.
    localparam logic [1:0] BUS_W32  = 2'b10;
    localparam logic [1:0] BUS_NONE = 2'b11;

    // Owner of the single framebuffer port for one cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VID  = 2'd1,
        GNT_WR   = 2'd2,
        GNT_RD   = 2'd3
    } grant_t;

endpackage

// File: rtl/baby_vga_fb_arbiter_if.sv
// TinyQV peripheral bus as seen by the framebuffer arbiter.
interface baby_vga_fb_arbiter_if;
    import baby_vga_pkg::*;

    logic [5:0]           address;
    logic [FB_DATA_W-1:0] data_in;
    logic [1:0]           data_write_n;
    logic [1:0]           data_read_n;
    logic [FB_DATA_W-1:0] data_out;
    logic                 data_ready;

    // CPU side drives the request, arbiter answers with read data.
    modport master (
        output address, data_in, data_write_n, data_read_n,
        input  data_out, data_ready
    );

    modport slave (
        input  address, data_in, data_write_n, data_read_n,
        output data_out, data_ready
    );

endinterface

// File: rtl/baby_vga_wfifo.sv
// Posted-write FIFO: drops a push when full unless the same cycle pops.
module baby_vga_wfifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign overflow = push && full && !pop_ok;
    assign pop_data = mem[rd_ptr[PTR_W-1:0]];

    // Pointer update on accepted push/pop.
    // NOTE: state registers use <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // Entry storage write.
    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/baby_vga_fb_arbiter.sv
// Single-port framebuffer scheduler: video fetch > posted CPU write > CPU read,
// with a starvation guard that forces one CPU slot after STARVE_MAX video grants.
module baby_vga_fb_arbiter
    import baby_vga_pkg::*;
#(
    parameter int ADDR_W      = FB_ADDR_W,
    parameter int DATA_W      = FB_DATA_W,
    parameter int WFIFO_DEPTH = 2,
    parameter int STARVE_MAX  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    baby_vga_fb_arbiter_if.slave  bus,
    input  logic                  vid_req,
    input  logic [3:0]            vid_row,
    output logic [DATA_W-1:0]     vid_line,
    output logic                  vid_ack,
    output logic [ADDR_W-1:0]     fb_addr,
    output logic                  fb_we,
    output logic [DATA_W-1:0]     fb_wdata,
    input  logic [DATA_W-1:0]     fb_rdata,
    input  logic                  clr_status,
    output logic                  wfifo_overflow,
    output logic                  vid_overrun
);

    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam int SC_W    = $clog2(STARVE_MAX + 1);

    grant_t               gnt;
    logic                 vid_pend;
    logic [ADDR_W-1:0]    vid_row_q;
    logic                 rd_pend;
    logic [ADDR_W-1:0]    rd_addr_q;
    logic [SC_W-1:0]      starve_cnt;
    logic                 s1_rd, s1_vid, s2_rd, s2_vid;
    logic [FB_DATA_W-1:0] data_out_q;
    logic                 data_ready_q;
    logic                 wr_cmd, rd_cmd, rd_busy, cpu_work, force_cpu, fifo_pop;
    logic                 fifo_empty, fifo_ovf, unused_full, unused_addr;
    logic [ENTRY_W-1:0]   fifo_out;
    logic [ADDR_W-1:0]    fifo_addr;
    logic [DATA_W-1:0]    fifo_data;

    assign unused_addr   = ^bus.address[1:0];
    assign wr_cmd        = (bus.data_write_n == BUS_W32);
    assign rd_cmd        = (bus.data_read_n == BUS_W32);
    // The CPU holds its read level until it sees data_ready, so the read is
    // outstanding from capture through the data_ready cycle itself.
    assign rd_busy       = rd_pend || (s1_rd && !s1_vid) || (s2_rd && !s2_vid) || data_ready_q;
    assign cpu_work      = !fifo_empty || rd_pend;
    assign force_cpu     = cpu_work && (starve_cnt == SC_W'(STARVE_MAX));
    assign fifo_pop      = (gnt == GNT_WR);
    assign {fifo_addr, fifo_data} = fifo_out;
    assign bus.data_out   = data_out_q;
    assign bus.data_ready = data_ready_q;

    baby_vga_wfifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (WFIFO_DEPTH)
    ) u_wfifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_cmd),
        .push_data ({ADDR_W'(bus.address[5:2]), DATA_W'(bus.data_in)}),
        .pop       (fifo_pop),
        .pop_data  (fifo_out),
        .full      (unused_full),
        .empty     (fifo_empty),
        .overflow  (fifo_ovf)
    );

    // Grant selection; reads wait for an empty FIFO to keep read-after-write order.
    // NOTE: default assigned first so no path leaves gnt unassigned (no latch).
    always_comb begin
        gnt = GNT_NONE;
        if (vid_pend && !force_cpu) gnt = GNT_VID;
        else if (!fifo_empty)       gnt = GNT_WR;
        else if (rd_pend)           gnt = GNT_RD;
    end

    // Capture pending video fetch and CPU read; a new vid_req beats a same-cycle grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vid_pend  <= 1'b0;
            vid_row_q <= '0;
            rd_pend   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            if (vid_req) begin
                vid_pend  <= 1'b1;
                vid_row_q <= ADDR_W'(vid_row);
            end else if (gnt == GNT_VID) begin
                vid_pend  <= 1'b0;
            end
            if (gnt == GNT_RD) begin
                rd_pend   <= 1'b0;
            end else if (rd_cmd && !rd_busy) begin
                rd_pend   <= 1'b1;
                rd_addr_q <= ADDR_W'(bus.address[5:2]);
            end
        end
    end

    // Count video grants that made CPU work wait; any CPU grant clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (gnt == GNT_WR || gnt == GNT_RD) begin
            starve_cnt <= '0;
        end else if (gnt == GNT_VID && cpu_work && starve_cnt != SC_W'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

    // Port stage: register the granted access onto the framebuffer port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_addr  <= '0;
            fb_we    <= 1'b0;
            fb_wdata <= '0;
            s1_rd    <= 1'b0;
            s1_vid   <= 1'b0;
            s2_rd    <= 1'b0;
            s2_vid   <= 1'b0;
        end else begin
            fb_we  <= (gnt == GNT_WR);
            s1_rd  <= (gnt == GNT_VID) || (gnt == GNT_RD);
            s1_vid <= (gnt == GNT_VID);
            s2_rd  <= s1_rd;
            s2_vid <= s1_vid;
            case (gnt)
                GNT_VID: fb_addr <= vid_row_q;
                GNT_RD:  fb_addr <= rd_addr_q;
                GNT_WR: begin
                    fb_addr  <= fifo_addr;
                    fb_wdata <= fifo_data;
                end
                default: ;
            endcase
        end
    end

    // Return stage: route fb_rdata by tag and pulse the matching ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vid_line     <= '0;
            vid_ack      <= 1'b0;
            data_out_q   <= '0;
            data_ready_q <= 1'b0;
        end else begin
            vid_ack      <= s2_rd && s2_vid;
            data_ready_q <= s2_rd && !s2_vid;
            if (s2_rd && s2_vid)  vid_line   <= fb_rdata;
            if (s2_rd && !s2_vid) data_out_q <= FB_DATA_W'(fb_rdata);
        end
    end

    // Sticky status; a set event in the clearing cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wfifo_overflow <= 1'b0;
            vid_overrun    <= 1'b0;
        end else begin
            if (fifo_ovf)        wfifo_overflow <= 1'b1;
            else if (clr_status) wfifo_overflow <= 1'b0;
            if (vid_req && vid_pend && gnt != GNT_VID) vid_overrun <= 1'b1;
            else if (clr_status)                       vid_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_baby_vga_fb_arbiter.sv
// Self-checking bench: framebuffer model plus expected-output queues for
// vid_line, data_out and framebuffer writes.
module tb_baby_vga_fb_arbiter;
    import baby_vga_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vid_req;
    logic [3:0]  vid_row;
    logic [31:0] vid_line;
    logic        vid_ack;
    logic [3:0]  fb_addr;
    logic        fb_we;
    logic [31:0] fb_wdata;
    logic [31:0] fb_rdata;
    logic        clr_status;
    logic        wfifo_overflow;
    logic        vid_overrun;

    baby_vga_fb_arbiter_if bus();

    baby_vga_fb_arbiter #(.STARVE_MAX(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .vid_req        (vid_req),
        .vid_row        (vid_row),
        .vid_line       (vid_line),
        .vid_ack        (vid_ack),
        .fb_addr        (fb_addr),
        .fb_we          (fb_we),
        .fb_wdata       (fb_wdata),
        .fb_rdata       (fb_rdata),
        .clr_status     (clr_status),
        .wfifo_overflow (wfifo_overflow),
        .vid_overrun    (vid_overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] vid_exp [$];
    logic [31:0] rd_exp  [$];
    logic [35:0] wr_exp  [$];
    logic [31:0] ref_mem [FB_LINES];
    logic [31:0] fb_mem  [FB_LINES];
    logic        mem_ready = 1'b0;

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0000_1111;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Framebuffer storage: synchronous read, data valid one cycle after fb_addr.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < FB_LINES; i++) fb_mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else begin
            if (fb_we) fb_mem[fb_addr] <= fb_wdata;
            fb_rdata <= fb_mem[fb_addr];
        end
    end

    // Output monitor: every ack / write must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (vid_ack) begin
                if (vid_exp.size() == 0) check("vid_ack_spurious", vid_ack, 0);
                else                     check("vid_line", vid_line, vid_exp.pop_front());
            end
            if (bus.data_ready) begin
                if (rd_exp.size() == 0) check("data_ready_spurious", bus.data_ready, 0);
                else                    check("data_out", bus.data_out, rd_exp.pop_front());
            end
            if (fb_we) begin
                if (wr_exp.size() == 0) check("fb_we_spurious", fb_we, 0);
                else                    check("fb_write", {fb_addr, fb_wdata}, wr_exp.pop_front());
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [3:0] line, input logic [31:0] d, input bit lands);
        bus.address      = {line, 2'b00};
        bus.data_in      = d;
        bus.data_write_n = BUS_W32;
        if (lands) begin
            ref_mem[line] = d;
            wr_exp.push_back({line, d});
        end
    endtask

    task automatic fetch(input logic [3:0] row, input bit lands);
        vid_req = 1'b1;
        vid_row = row;
        if (lands) vid_exp.push_back(ref_mem[row]);
    endtask

    task automatic idle();
        vid_req          = 1'b0;
        bus.data_write_n = BUS_NONE;
        clr_status       = 1'b0;
    endtask

    initial begin
        int lat;
        for (int i = 0; i < FB_LINES; i++) ref_mem[i] = init_word(i);
        rst_n           = 1'b0;
        vid_row         = '0;
        bus.address     = '0;
        bus.data_in     = '0;
        bus.data_read_n = BUS_NONE;
        idle();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_fb_port", {fb_addr, fb_we, fb_wdata}, 0);
        check("rst_vid", {vid_line, vid_ack}, 0);
        check("rst_cpu", {bus.data_out, bus.data_ready}, 0);
        check("rst_flags", {wfifo_overflow, vid_overrun}, 0);
        rst_n = 1'b1;
        tick(); tick();

        // 1: idle fetch of row 5 -> fb_addr at N+2, vid_ack at N+4.
        fetch(4'd5, 1'b1);
        tick(); idle();
        tick();
        check("t1_fb_addr", fb_addr, 5);
        check("t1_fb_we", fb_we, 0);
        tick();
        check("t1_ack_early", vid_ack, 0);
        tick();
        check("t1_vid_ack", vid_ack, 1);
        tick(); tick();

        // 2: write line 3 then read it back; read waits for the FIFO to drain.
        cpu_write(4'd3, 32'hA5A5_0001, 1'b1);
        tick(); idle();
        bus.address     = 6'h0C;
        bus.data_read_n = BUS_W32;
        rd_exp.push_back(ref_mem[3]);
        tick();
        check("t2_fb_we", fb_we, 1);
        lat = 0;
        while (!bus.data_ready && lat < 20) begin
            tick();
            lat++;
        end
        check("t2_rd_latency", lat, 3);
        bus.data_read_n = BUS_NONE;
        tick();
        check("t2_ready_pulse", bus.data_ready, 0);
        check("t2_data_hold", bus.data_out, 32'hA5A5_0001);
        tick(); tick();

        // 3: writes blocked by two video grants; third dropped, fourth pushed while popping.
        fetch(4'd1, 1'b1);
        cpu_write(4'd8, 32'h1111_0008, 1'b1);
        tick();
        fetch(4'd2, 1'b1);
        cpu_write(4'd9, 32'h2222_0009, 1'b1);
        tick();
        vid_req = 1'b0;
        cpu_write(4'd10, 32'h3333_000A, 1'b0);
        tick();
        check("t3_overflow_set", wfifo_overflow, 1);
        check("t3_fb_we_blocked", fb_we, 0);
        cpu_write(4'd11, 32'h4444_000B, 1'b1);
        tick(); idle();
        check("t3_first_write", fb_we, 1);
        clr_status = 1'b1;
        tick(); idle();
        check("t3_overflow_clr", wfifo_overflow, 0);
        repeat (4) tick();

        // 4/5: starvation forces the write after 2 video grants; row 3 overwritten by 7.
        fetch(4'd0, 1'b1);
        cpu_write(4'd12, 32'h5555_000C, 1'b1);
        tick(); idle();
        fetch(4'd1, 1'b1);
        tick();
        fetch(4'd3, 1'b0);
        tick();
        check("t4_fb_we_vid", fb_we, 0);
        fetch(4'd7, 1'b0);
        clr_status = 1'b1;
        tick(); idle();
        vid_exp.push_back(ref_mem[7]);
        check("t4_forced_write", fb_we, 1);
        check("t4_overrun_set", vid_overrun, 1);
        tick();
        check("t4_fetch_row7", fb_addr, 7);
        clr_status = 1'b1;
        tick(); idle();
        check("t4_overrun_clr", vid_overrun, 0);
        repeat (4) tick();

        // 5: video and write in the same cycle -> video grant first.
        fetch(4'd4, 1'b1);
        cpu_write(4'd13, 32'h6666_000D, 1'b1);
        tick(); idle();
        tick();
        check("t5_vid_first", {fb_addr, fb_we}, {4'd4, 1'b0});
        tick();
        check("t5_write_next", {fb_addr, fb_we}, {4'd13, 1'b1});
        repeat (5) tick();

        // 6: async reset with fetch in flight, read pending and FIFO occupied.
        fetch(4'd2, 1'b0);
        cpu_write(4'd9, 32'hDEAD_0009, 1'b0);
        tick(); idle();
        fetch(4'd6, 1'b0);
        bus.address     = 6'h14;
        bus.data_read_n = BUS_W32;
        tick(); idle();
        check("t6_pre_addr", fb_addr, 2);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_fb_port", {fb_addr, fb_we, fb_wdata}, 0);
        check("t6_rst_vid", {vid_line, vid_ack}, 0);
        check("t6_rst_cpu", {bus.data_out, bus.data_ready}, 0);
        bus.data_read_n = BUS_NONE;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t6_quiet", {vid_ack, bus.data_ready, fb_we}, 0);
        end

        check("vid_exp_left", vid_exp.size(), 0);
        check("rd_exp_left", rd_exp.size(), 0);
        check("wr_exp_left", wr_exp.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
